// File: rtl/spi_slave_response_transmitter.sv
// -----------------------------------------------------------------------------
// spi_slave_response_transmitter
//
// MISO-side companion to the SPI slave command receiver. Response entries
// (1..5 bytes, e.g. R1 / R3 / R7) are pushed through an Avalon-MM slave into
// a small FIFO. Each rising edge of io_ArgumentReadFinished arms one response,
// which is shifted out MSB first after NCR filler bytes of 0xFF.
//
// Optional build macro: SPI_TX_STATS_EN adds sent/aborted counters at addr 2.
//
// Ports:
//   clock, reset               system clock, synchronous active-high reset
//   io_Avalon_*                Avalon-MM slave (addr 0 STATUS, addr 1 PUSH)
//   io_SpiSck, io_SpiCsN       asynchronous SPI mode-0 clock / chip select
//   io_SpiMiso                 registered serial output, idles high
//   io_ArgumentReadFinished    level from receiver, rising edge arms a response
// -----------------------------------------------------------------------------
module spi_slave_response_transmitter #(
    parameter int FIFO_DEPTH = 8,
    parameter int NCR        = 1,
    parameter int NCR_LATE   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  io_Avalon_address,
    input  logic        io_Avalon_read,
    output logic [63:0] io_Avalon_readdata,
    input  logic        io_Avalon_write,
    input  logic [63:0] io_Avalon_writedata,
    output logic        io_Avalon_waitrequest,
    input  logic        io_SpiSck,
    input  logic        io_SpiCsN,
    output logic        io_SpiMiso,
    input  logic        io_ArgumentReadFinished
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_NCR, SEND} state_t;

    state_t      state;
    logic        sck_meta, sck_sync, sck_prev;
    logic        csn_meta, csn_sync, csn_prev;
    logic        arm_prev;
    logic [2:0]  bit_cnt;
    logic [2:0]  byte_idx;
    logic [7:0]  fillcnt;
    logic        miso;
    logic        late, abort_flag, arm_overrun, bad_len;

    logic [39:0] fifo_payload [FIFO_DEPTH];
    logic [2:0]  fifo_len     [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    // Edge events on the synchronised SPI pins; SCK is ignored while deselected.
    logic sck_rise, sck_fall, csn_rise, csn_fall, byte_end, arm;
    assign sck_rise = ~csn_sync & sck_sync & ~sck_prev;
    assign sck_fall = ~csn_sync & ~sck_sync & sck_prev;
    assign csn_rise = csn_sync & ~csn_prev;
    assign csn_fall = ~csn_sync & csn_prev;
    assign byte_end = sck_rise && (bit_cnt == 3'd7);
    assign arm      = io_ArgumentReadFinished & ~arm_prev;

    logic fifo_empty, fifo_full;
    logic [4:0] level;
    assign fifo_empty = (count == '0);
    assign fifo_full  = count[AW];
    assign level      = 5'(count);

    // Byte index 0 is the most significant of the n valid payload bytes.
    logic [39:0] head_payload, head_shifted;
    logic [2:0]  head_len, head_byte_sel;
    logic [7:0]  cur_byte;
    assign head_payload  = fifo_payload[rd_ptr];
    assign head_len      = fifo_len[rd_ptr];
    assign head_byte_sel = head_len - 3'd1 - byte_idx;
    assign head_shifted  = head_payload >> {head_byte_sel, 3'b000};
    assign cur_byte      = (state == SEND) ? head_shifted[7:0] : 8'hFF;

    logic [7:0] fill_next;
    logic       send_start, abort_evt, last_byte, pop;
    assign fill_next  = (fillcnt == 8'hFF) ? fillcnt : fillcnt + 8'd1;
    assign send_start = (state == WAIT_NCR) && byte_end && (fill_next >= 8'(NCR)) && !fifo_empty;
    assign abort_evt  = (state == SEND) && csn_rise;
    assign last_byte  = (byte_idx == head_len - 3'd1);
    assign pop        = abort_evt || ((state == SEND) && byte_end && last_byte);

    // A pop in the same cycle frees a slot, so a stalled push completes then.
    logic       push_req, push, len_ok, status_wr;
    logic [2:0] push_len;
    assign push_req              = io_Avalon_write && (io_Avalon_address == 6'd1);
    assign io_Avalon_waitrequest = push_req && fifo_full && !pop;
    assign push_len              = io_Avalon_writedata[42:40];
    assign len_ok                = (push_len != 3'd0) && (push_len <= 3'd5);
    assign push                  = push_req && !io_Avalon_waitrequest && len_ok;
    assign status_wr             = io_Avalon_write && (io_Avalon_address == 6'd0);

    logic late_set, overrun_set, bad_len_set;
    assign late_set    = (state == WAIT_NCR) && byte_end && (fill_next == 8'(NCR_LATE)) && fifo_empty;
    assign overrun_set = arm && (state != IDLE);
    assign bad_len_set = push_req && !io_Avalon_waitrequest && !len_ok;

    assign io_SpiMiso = miso;

    // Synchronisers, bit timing and the byte-granular response state machine.
    always_ff @(posedge clock) begin
        if (reset) begin
            sck_meta <= 1'b0;
            sck_sync <= 1'b0;
            sck_prev <= 1'b0;
            csn_meta <= 1'b1;
            csn_sync <= 1'b1;
            csn_prev <= 1'b1;
            arm_prev <= 1'b1;
            bit_cnt  <= 3'd0;
            miso     <= 1'b1;
            state    <= IDLE;
            byte_idx <= 3'd0;
            fillcnt  <= 8'd0;
        end else begin
            sck_meta <= io_SpiSck;
            sck_sync <= sck_meta;
            sck_prev <= sck_sync;
            csn_meta <= io_SpiCsN;
            csn_sync <= csn_meta;
            csn_prev <= csn_sync;
            arm_prev <= io_ArgumentReadFinished;

            if (csn_sync || csn_fall) begin
                bit_cnt <= 3'd0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (csn_sync) begin
                miso <= 1'b1;
            end else if (csn_fall) begin
                miso <= cur_byte[7];
            end else if (sck_fall) begin
                miso <= cur_byte[3'd7 - bit_cnt];
            end

            case (state)
                IDLE: begin
                    if (arm) begin
                        state   <= WAIT_NCR;
                        fillcnt <= 8'd0;
                    end
                end
                WAIT_NCR: begin
                    if (byte_end) begin
                        fillcnt <= fill_next;
                    end
                    if (send_start) begin
                        state    <= SEND;
                        byte_idx <= 3'd0;
                    end
                end
                SEND: begin
                    if (abort_evt) begin
                        state    <= IDLE;
                        byte_idx <= 3'd0;
                    end else if (byte_end) begin
                        if (last_byte) begin
                            state    <= IDLE;
                            byte_idx <= 3'd0;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_payload[wr_ptr] <= io_Avalon_writedata[39:0];
            fifo_len[wr_ptr]     <= push_len;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Sticky flags: a set in the same cycle as a W1C clear wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            late        <= 1'b0;
            abort_flag  <= 1'b0;
            arm_overrun <= 1'b0;
            bad_len     <= 1'b0;
        end else begin
            late        <= (late        & ~(status_wr & io_Avalon_writedata[8]))  | late_set;
            abort_flag  <= (abort_flag  & ~(status_wr & io_Avalon_writedata[9]))  | abort_evt;
            arm_overrun <= (arm_overrun & ~(status_wr & io_Avalon_writedata[10])) | overrun_set;
            bad_len     <= (bad_len     & ~(status_wr & io_Avalon_writedata[11])) | bad_len_set;
        end
    end

`ifdef SPI_TX_STATS_EN
    logic [15:0] sent_count, aborted_count;
    logic        stats_clr;
    assign stats_clr = io_Avalon_write && (io_Avalon_address == 6'd2);

    always_ff @(posedge clock) begin
        if (reset || stats_clr) begin
            sent_count    <= 16'd0;
            aborted_count <= 16'd0;
        end else begin
            if (pop && !abort_evt) sent_count    <= sent_count + 16'd1;
            if (abort_evt)         aborted_count <= aborted_count + 16'd1;
        end
    end
`endif

    always_comb begin
        io_Avalon_readdata = '0;
        case (io_Avalon_address)
            6'd0: io_Avalon_readdata = {52'd0, bad_len, arm_overrun, abort_flag, late,
                                        (state != IDLE), fifo_empty, fifo_full, level};
`ifdef SPI_TX_STATS_EN
            6'd2: io_Avalon_readdata = {32'd0, sent_count, aborted_count};
`endif
            default: io_Avalon_readdata = '0;
        endcase
    end

    // Read data is combinational, so the read strobe and upper write bits carry no meaning.
    logic unused_inputs;
    assign unused_inputs = ^{io_Avalon_read, io_Avalon_writedata[63:43]};

endmodule

// File: tb/tb_spi_slave_response_transmitter.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_response_transmitter
//
// Self-checking bench for spi_slave_response_transmitter. Drives the Avalon
// slave and an SPI mode-0 host, and compares every received MISO byte and
// STATUS word against a queue-based model of the response FIFO.
// -----------------------------------------------------------------------------
module tb_spi_slave_response_transmitter;
    localparam int FIFO_DEPTH_TB = 8;
    localparam int NCR_TB        = 1;
    localparam int NCR_LATE_TB   = 8;
    localparam int HALF          = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  io_Avalon_address;
    logic        io_Avalon_read;
    logic [63:0] io_Avalon_readdata;
    logic        io_Avalon_write;
    logic [63:0] io_Avalon_writedata;
    logic        io_Avalon_waitrequest;
    logic        io_SpiSck;
    logic        io_SpiCsN;
    logic        io_SpiMiso;
    logic        io_ArgumentReadFinished;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [39:0] payload;
        int          len;
    } entry_t;

    entry_t model_q[$];

    spi_slave_response_transmitter #(
        .FIFO_DEPTH (FIFO_DEPTH_TB),
        .NCR        (NCR_TB),
        .NCR_LATE   (NCR_LATE_TB)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .io_Avalon_address       (io_Avalon_address),
        .io_Avalon_read          (io_Avalon_read),
        .io_Avalon_readdata      (io_Avalon_readdata),
        .io_Avalon_write         (io_Avalon_write),
        .io_Avalon_writedata     (io_Avalon_writedata),
        .io_Avalon_waitrequest   (io_Avalon_waitrequest),
        .io_SpiSck               (io_SpiSck),
        .io_SpiCsN               (io_SpiCsN),
        .io_SpiMiso              (io_SpiMiso),
        .io_ArgumentReadFinished (io_ArgumentReadFinished)
    );

    always #5 clock = ~clock;

    // Byte i of an n-byte response is the i-th most significant of the low n bytes.
    function automatic logic [7:0] expected_byte(input logic [39:0] payload, input int len, input int idx);
        logic [39:0] shifted;
        shifted = payload >> (8 * (len - 1 - idx));
        return shifted[7:0];
    endfunction

    function automatic logic [63:0] push_word(input logic [39:0] payload, input int len);
        logic [2:0] n;
        n = 3'(len);
        return {21'd0, n, payload};
    endfunction

    function automatic logic [39:0] rand_payload();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[39:0];
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset                   = 1'b1;
        io_SpiCsN               = 1'b1;
        io_SpiSck               = 1'b0;
        io_Avalon_write         = 1'b0;
        io_Avalon_read          = 1'b0;
        io_Avalon_address       = 6'd0;
        io_Avalon_writedata     = 64'd0;
        io_ArgumentReadFinished = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        model_q.delete();
    endtask

    task automatic avalon_write(input logic [5:0] addr, input logic [63:0] data);
        int waited;
        @(negedge clock);
        io_Avalon_address   = addr;
        io_Avalon_writedata = data;
        io_Avalon_write     = 1'b1;
        #1;
        waited = 0;
        while (io_Avalon_waitrequest && waited < 100) begin
            @(negedge clock);
            #1;
            waited++;
        end
        if (io_Avalon_waitrequest) begin
            checks++;
            $display("[TB] FAIL write_timeout: waitrequest=%0b required 0 within 100 cycles", io_Avalon_waitrequest);
        end
        @(posedge clock);
        #1 io_Avalon_write = 1'b0;
    endtask

    task automatic avalon_read(input logic [5:0] addr, output logic [63:0] data);
        @(negedge clock);
        io_Avalon_address = addr;
        io_Avalon_read    = 1'b1;
        #1 data = io_Avalon_readdata;
        io_Avalon_read = 1'b0;
    endtask

    task automatic pulse_arm();
        @(negedge clock);
        io_ArgumentReadFinished = 1'b1;
        repeat (2) @(negedge clock);
        io_ArgumentReadFinished = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic cs_low();
        @(negedge clock);
        io_SpiCsN = 1'b0;
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clock);
        io_SpiCsN = 1'b1;
        repeat (10) @(negedge clock);
    endtask

    // Host samples just before each rising SCK, as a mode-0 master would.
    task automatic clock_bits(input int nbits, output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            repeat (HALF) @(negedge clock);
            b[7 - i] = io_SpiMiso;
            io_SpiSck = 1'b1;
            repeat (HALF) @(negedge clock);
            io_SpiSck = 1'b0;
        end
    endtask

    task automatic clock_byte(output logic [7:0] b);
        clock_bits(8, b);
    endtask

    task automatic test_reset();
        logic [63:0] rd;
        do_reset();
        checks++;
        if (io_SpiMiso !== 1'b1) $display("[TB] FAIL reset_miso: got %b expected 1", io_SpiMiso);
        else passes++;
        checks++;
        if (io_Avalon_waitrequest !== 1'b0) $display("[TB] FAIL reset_waitrequest: got %b expected 0", io_Avalon_waitrequest);
        else passes++;
        avalon_read(6'd0, rd);
        checks++;
        if (rd !== 64'h40) $display("[TB] FAIL reset_status: got %h expected %h", rd, 64'h40);
        else passes++;
        avalon_read(6'd1, rd);
        checks++;
        if (rd !== 64'h0) $display("[TB] FAIL push_reads_zero: got %h expected 0", rd);
        else passes++;
        avalon_read(6'd9, rd);
        checks++;
        if (rd !== 64'h0) $display("[TB] FAIL unmapped_read: got %h expected 0", rd);
        else passes++;
`ifndef SPI_TX_STATS_EN
        avalon_read(6'd2, rd);
        checks++;
        if (rd !== 64'h0) $display("[TB] FAIL stats_absent: got %h expected 0", rd);
        else passes++;
`endif
    endtask

    task automatic test_r1();
        logic [7:0]  b;
        logic [7:0]  exp_bytes[3];
        logic [63:0] rd;
        exp_bytes = '{8'hFF, 8'h00, 8'hFF};
        do_reset();
        avalon_write(6'd1, push_word(40'h0, 1));
        pulse_arm();
        cs_low();
        for (int i = 0; i < 3; i++) begin
            clock_byte(b);
            checks++;
            if (b !== exp_bytes[i]) $display("[TB] FAIL r1_byte%0d: got %h expected %h", i, b, exp_bytes[i]);
            else passes++;
        end
        cs_high();
        avalon_read(6'd0, rd);
        checks++;
        if (rd !== 64'h40) $display("[TB] FAIL r1_status: got %h expected %h", rd, 64'h40);
        else passes++;
    endtask

    task automatic test_r7();
        logic [7:0] b;
        logic [7:0] exp_bytes[7];
        exp_bytes = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hFF};
        do_reset();
        avalon_write(6'd1, push_word(40'h01_000001AA, 5));
        pulse_arm();
        cs_low();
        for (int i = 0; i < 7; i++) begin
            clock_byte(b);
            checks++;
            if (b !== exp_bytes[i]) $display("[TB] FAIL r7_byte%0d: got %h expected %h", i, b, exp_bytes[i]);
            else passes++;
        end
        cs_high();
    endtask

    task automatic test_random_sessions();
        logic [7:0]  b;
        logic [63:0] rd;
        entry_t      e;
        do_reset();
        cs_low();
        for (int iter = 0; iter < 5; iter++) begin
            int k;
            k = $urandom_range(1, 3);
            for (int j = 0; j < k; j++) begin
                e.payload = rand_payload();
                e.len     = $urandom_range(1, 5);
                avalon_write(6'd1, push_word(e.payload, e.len));
                model_q.push_back(e);
            end
            while (model_q.size() > 0) begin
                e = model_q.pop_front();
                if ($urandom_range(0, 1) == 1) begin
                    cs_high();
                    cs_low();
                end
                pulse_arm();
                for (int f = 0; f < NCR_TB; f++) begin
                    clock_byte(b);
                    checks++;
                    if (b !== 8'hFF) $display("[TB] FAIL rand_filler: got %h expected ff", b);
                    else passes++;
                end
                for (int i = 0; i < e.len; i++) begin
                    clock_byte(b);
                    checks++;
                    if (b !== expected_byte(e.payload, e.len, i))
                        $display("[TB] FAIL rand_byte: iter %0d idx %0d got %h expected %h",
                                 iter, i, b, expected_byte(e.payload, e.len, i));
                    else passes++;
                end
            end
        end
        cs_high();
        avalon_read(6'd0, rd);
        checks++;
        if (rd !== 64'h40) $display("[TB] FAIL rand_status: got %h expected %h", rd, 64'h40);
        else passes++;
    endtask

    task automatic test_late();
        logic [7:0]  b;
        logic [63:0] rd;
        logic [7:0]  exp_bytes[3];
        exp_bytes = '{8'hFF, 8'h05, 8'hFF};
        do_reset();
        pulse_arm();
        cs_low();
        for (int i = 0; i < NCR_LATE_TB + 1; i++) begin
            clock_byte(b);
            checks++;
            if (b !== 8'hFF) $display("[TB] FAIL late_filler%0d: got %h expected ff", i, b);
            else passes++;
        end
        avalon_read(6'd0, rd);
        checks++;
        if (rd !== 64'h1C0) $display("[TB] FAIL late_status: got %h expected %h", rd, 64'h1C0);
        else passes++;
        avalon_write(6'd1, push_word(40'h05, 1));
        for (int i = 0; i < 3; i++) begin
            clock_byte(b);
            checks++;
            if (b !== exp_bytes[i]) $display("[TB] FAIL late_byte%0d: got %h expected %h", i, b, exp_bytes[i]);
            else passes++;
        end
        avalon_read(6'd0, rd);
        checks++;
        if (rd !== 64'h140) $display("[TB] FAIL late_sticky: got %h expected %h", rd, 64'h140);
        else passes++;
        avalon_write(6'd0, 64'h100);
        avalon_read(6'd0, rd);
        checks++;
        if (rd !== 64'h40) $display("[TB] FAIL late_w1c: got %h expected %h", rd, 64'h40);
        else passes++;
        cs_high();
    endtask

    task automatic test_full();
        logic [7:0]  b0, b1;
        logic [63:0] rd;
        logic [39:0] p9;
        logic        wait_seen, accepted;
        entry_t      e;
        do_reset();
        for (int i = 0; i < FIFO_DEPTH_TB; i++) begin
            e.payload = 40'($urandom_range(0, 255));
            e.len     = 1;
            avalon_write(6'd1, push_word(e.payload, 1));
            model_q.push_back(e);
        end
        avalon_read(6'd0, rd);
        checks++;
        if (rd !== 64'h28) $display("[TB] FAIL full_status: got %h expected %h", rd, 64'h28);
        else passes++;
        cs_low();
        pulse_arm();
        p9 = 40'($urandom_range(0, 255));
        @(negedge clock);
        io_Avalon_address   = 6'd1;
        io_Avalon_writedata = push_word(p9, 1);
        io_Avalon_write     = 1'b1;
        #1 wait_seen = io_Avalon_waitrequest;
        checks++;
        if (wait_seen !== 1'b1) $display("[TB] FAIL full_waitrequest: got %b expected 1", wait_seen);
        else passes++;
        accepted = 1'b0;
        fork
            begin
                clock_byte(b0);
                clock_byte(b1);
            end
            begin
                for (int c = 0; c < 2000; c++) begin
                    @(negedge clock);
                    if (!io_Avalon_waitrequest) begin
                        accepted = 1'b1;
                        break;
                    end
                end
                @(posedge clock);
                #1 io_Avalon_write = 1'b0;
            end
        join
        checks++;
        if (accepted !== 1'b1) $display("[TB] FAIL full_accept: got %b expected 1", accepted);
        else passes++;
        e = model_q.pop_front();
        checks++;
        if (b0 !== 8'hFF) $display("[TB] FAIL full_filler: got %h expected ff", b0);
        else passes++;
        checks++;
        if (b1 !== e.payload[7:0]) $display("[TB] FAIL full_first: got %h expected %h", b1, e.payload[7:0]);
        else passes++;
        e.payload = p9;
        e.len     = 1;
        model_q.push_back(e);
        avalon_read(6'd0, rd);
        checks++;
        if (rd !== 64'h28) $display("[TB] FAIL full_level8: got %h expected %h", rd, 64'h28);
        else passes++;
        while (model_q.size() > 0) begin
            e = model_q.pop_front();
            pulse_arm();
            clock_byte(b0);
            clock_byte(b1);
            checks++;
            if (b0 !== 8'hFF || b1 !== e.payload[7:0])
                $display("[TB] FAIL full_drain: got %h %h expected ff %h", b0, b1, e.payload[7:0]);
            else passes++;
        end
        avalon_read(6'd0, rd);
        checks++;
        if (rd !== 64'h40) $display("[TB] FAIL full_drained: got %h expected %h", rd, 64'h40);
        else passes++;
        cs_high();
    endtask

    task automatic test_abort();
        logic [7:0]  b;
        logic [63:0] rd;
        entry_t      e1, e2;
        do_reset();
        e1.payload = rand_payload();
        e1.len     = 5;
        e2.payload = rand_payload();
        e2.len     = $urandom_range(1, 5);
        avalon_write(6'd1, push_word(e1.payload, e1.len));
        avalon_write(6'd1, push_word(e2.payload, e2.len));
        cs_low();
        pulse_arm();
        clock_byte(b);
        checks++;
        if (b !== 8'hFF) $display("[TB] FAIL abort_filler: got %h expected ff", b);
        else passes++;
        clock_byte(b);
        checks++;
        if (b !== expected_byte(e1.payload, 5, 0)) $display("[TB] FAIL abort_first: got %h expected %h", b, expected_byte(e1.payload, 5, 0));
        else passes++;
        cs_high();
        checks++;
        if (io_SpiMiso !== 1'b1) $display("[TB] FAIL abort_miso_idle: got %b expected 1", io_SpiMiso);
        else passes++;
        avalon_read(6'd0, rd);
        checks++;
        if (rd !== 64'h201) $display("[TB] FAIL abort_status: got %h expected %h", rd, 64'h201);
        else passes++;
        avalon_write(6'd0, 64'h200);
        avalon_read(6'd0, rd);
        checks++;
        if (rd !== 64'h001) $display("[TB] FAIL abort_w1c: got %h expected %h", rd, 64'h001);
        else passes++;
        cs_low();
        pulse_arm();
        clock_byte(b);
        checks++;
        if (b !== 8'hFF) $display("[TB] FAIL abort_next_filler: got %h expected ff", b);
        else passes++;
        for (int i = 0; i < e2.len; i++) begin
            clock_byte(b);
            checks++;
            if (b !== expected_byte(e2.payload, e2.len, i))
                $display("[TB] FAIL abort_next_byte%0d: got %h expected %h", i, b, expected_byte(e2.payload, e2.len, i));
            else passes++;
        end
        cs_high();
    endtask

    task automatic test_bad_len_overrun();
        logic [7:0]  b;
        logic [63:0] rd;
        entry_t      e;
        do_reset();
        avalon_write(6'd1, push_word(rand_payload(), 0));
        avalon_read(6'd0, rd);
        checks++;
        if (rd !== 64'h840) $display("[TB] FAIL badlen_zero: got %h expected %h", rd, 64'h840);
        else passes++;
        avalon_write(6'd0, 64'h800);
        avalon_write(6'd1, push_word(rand_payload(), 6));
        avalon_read(6'd0, rd);
        checks++;
        if (rd !== 64'h840) $display("[TB] FAIL badlen_six: got %h expected %h", rd, 64'h840);
        else passes++;
        avalon_write(6'd0, 64'h800);
        e.payload = rand_payload();
        e.len     = 3;
        avalon_write(6'd1, push_word(e.payload, e.len));
        cs_low();
        pulse_arm();
        clock_byte(b);
        clock_byte(b);
        checks++;
        if (b !== expected_byte(e.payload, 3, 0)) $display("[TB] FAIL overrun_b0: got %h expected %h", b, expected_byte(e.payload, 3, 0));
        else passes++;
        pulse_arm();
        avalon_read(6'd0, rd);
        checks++;
        if (rd !== 64'h481) $display("[TB] FAIL overrun_status: got %h expected %h", rd, 64'h481);
        else passes++;
        for (int i = 1; i < 3; i++) begin
            clock_byte(b);
            checks++;
            if (b !== expected_byte(e.payload, 3, i))
                $display("[TB] FAIL overrun_byte%0d: got %h expected %h", i, b, expected_byte(e.payload, 3, i));
            else passes++;
        end
        avalon_read(6'd0, rd);
        checks++;
        if (rd !== 64'h440) $display("[TB] FAIL overrun_done: got %h expected %h", rd, 64'h440);
        else passes++;
        cs_high();
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0]  b;
        logic [63:0] rd;
        do_reset();
        avalon_write(6'd1, push_word(40'h0, 1));
        pulse_arm();
        cs_low();
        clock_byte(b);
        clock_bits(3, b);
        repeat (4) @(negedge clock);
        checks++;
        if (io_SpiMiso !== 1'b0) $display("[TB] FAIL midbyte_miso_before: got %b expected 0", io_SpiMiso);
        else passes++;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (io_SpiMiso !== 1'b1) $display("[TB] FAIL midbyte_miso_reset: got %b expected 1", io_SpiMiso);
        else passes++;
        @(negedge clock);
        reset = 1'b0;
        avalon_read(6'd0, rd);
        checks++;
        if (rd !== 64'h40) $display("[TB] FAIL midbyte_flushed: got %h expected %h", rd, 64'h40);
        else passes++;
        cs_high();
    endtask

    initial begin
        test_reset();
        test_r1();
        test_r7();
        test_random_sessions();
        test_late();
        test_full();
        test_abort();
        test_bad_len_overrun();
        test_reset_mid_byte();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
